// File: rtl/elastic_fifo_opaque_pkg.sv
// Shared definitions for the registered-output elastic FIFO.
package elastic_fifo_opaque_pkg;

  // Pointer/counter width helper; never returns less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/elastic_fifo_opaque_if.sv
// Handshake bundle between a producer, the FIFO and a consumer.
interface elastic_fifo_opaque_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DATA_TYPE-1:0] outs;
  logic                 outs_valid;
  logic                 outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  outs, outs_valid, ins_ready
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output outs, outs_valid, ins_ready
  );
endinterface

// File: rtl/elastic_fifo_opaque_fifo_ring_mem.sv
// Ring buffer behind the head register: one write port, asynchronous read port,
// modulo-DEPTH pointers (DEPTH need not be a power of two).
module elastic_fifo_opaque_fifo_ring_mem
  import elastic_fifo_opaque_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter int  WIDTH = 32,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage array; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign full    = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/elastic_fifo_opaque.sv
// Opaque elastic FIFO: head register plus ring buffer; outs, outs_valid and
// ins_ready are all register outputs, so no input reaches an output combinationally.
module elastic_fifo_opaque
  import elastic_fifo_opaque_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  elastic_fifo_opaque_if.slave  io
);

  localparam int RB_DEPTH = NUM_SLOTS - 1;
  localparam int CNT_W    = clog2_min1(RB_DEPTH + 1);
  localparam int OCC_W    = clog2_min1(NUM_SLOTS + 1);

  generate
    if (NUM_SLOTS < 2) begin : g_bad_slots
      $error("elastic_fifo_opaque: NUM_SLOTS must be at least 2");
    end
    if (DATA_TYPE < 1) begin : g_bad_width
      $error("elastic_fifo_opaque: DATA_TYPE must be at least 1");
    end
  endgenerate

  logic                 hr_valid_r;
  logic [DATA_TYPE-1:0] hr_data_r;
  logic                 ins_ready_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 hr_free_s;
  logic                 refill_s;
  logic                 bypass_s;
  logic                 rb_wr_s;
  logic                 rb_empty_s;
  logic                 rb_full_s;
  logic [CNT_W-1:0]     rb_count_s;
  logic [DATA_TYPE-1:0] rb_rd_data_s;
  logic [OCC_W-1:0]     occ_s;
  logic [OCC_W-1:0]     occ_next_s;

  // Handshake decode and routing: the ring buffer has priority over the bypass so
  // a token arriving while older ones are queued never overtakes them.
  always_comb begin
    push_s     = io.ins_valid & ins_ready_r;
    pop_s      = hr_valid_r & io.outs_ready;
    hr_free_s  = ~hr_valid_r | pop_s;
    refill_s   = 1'b0;
    bypass_s   = 1'b0;
    if (hr_free_s && !rb_empty_s) begin
      refill_s = 1'b1;
    end else if (hr_free_s && push_s) begin
      bypass_s = 1'b1;
    end else begin
      refill_s = 1'b0;
      bypass_s = 1'b0;
    end
    rb_wr_s    = push_s & ~bypass_s & ~rb_full_s;
    occ_s      = OCC_W'(hr_valid_r) + OCC_W'(rb_count_s);
    occ_next_s = occ_s + OCC_W'(push_s) - OCC_W'(pop_s);
  end

  elastic_fifo_opaque_fifo_ring_mem #(
    .DEPTH (RB_DEPTH),
    .WIDTH (DATA_TYPE)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rb_wr_s),
    .wr_data (io.ins),
    .rd_en   (refill_s),
    .rd_data (rb_rd_data_s),
    .count   (rb_count_s),
    .empty   (rb_empty_s),
    .full    (rb_full_s)
  );

  // Head register and registered ready; ready lags a full-state pop by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_valid_r  <= 1'b0;
      hr_data_r   <= {DATA_TYPE{1'b0}};
      ins_ready_r <= 1'b0;
    end else begin
      if (refill_s) begin
        hr_valid_r <= 1'b1;
        hr_data_r  <= rb_rd_data_s;
      end else if (bypass_s) begin
        hr_valid_r <= 1'b1;
        hr_data_r  <= io.ins;
      end else if (pop_s) begin
        hr_valid_r <= 1'b0;
      end else begin
        hr_valid_r <= hr_valid_r;
      end
      ins_ready_r <= (occ_next_s < OCC_W'(NUM_SLOTS));
    end
  end

  assign io.outs       = hr_data_r;
  assign io.outs_valid = hr_valid_r;
  assign io.ins_ready  = ins_ready_r;

endmodule

// File: tb/tb_elastic_fifo_opaque.sv
// Directed vector table plus hand-written corner sequences and a scoreboarded random run.
module tb_elastic_fifo_opaque;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eov;
    logic [W-1:0] eouts;
    logic         erdy;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl [15];

  elastic_fifo_opaque_if #(.DATA_TYPE(W)) bus ();

  elastic_fifo_opaque #(.NUM_SLOTS(N), .DATA_TYPE(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    bus.ins_valid  = iv;
    bus.ins        = d;
    bus.outs_ready = ordy;
  endtask

  initial begin
    logic [W-1:0] q [$];
    logic         rdy_m;
    logic         push_m;
    logic         pop_m;
    logic         stall_m;
    logic [W-1:0] held_m;

    total = 0;
    bad   = 0;
    // iv, d, ordy, exp outs_valid, exp outs, exp ins_ready (after the edge)
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[9]  = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h66, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

    // Reset held with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(1)), W'($urandom_range(255)), 1'($urandom_range(1)));
      step();
      chk("rst_outs_valid", 32'(bus.outs_valid), 32'd0);
      chk("rst_ins_ready", 32'(bus.ins_ready), 32'd0);
      chk("rst_outs", 32'(bus.outs), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    chk("release_ins_ready", 32'(bus.ins_ready), 32'd1);
    chk("release_outs_valid", 32'(bus.outs_valid), 32'd0);

    // Directed table: fill to full, held token, drain with wrap, bypass cases.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_outs_valid", i), 32'(bus.outs_valid), 32'(tbl[i].eov));
      chk($sformatf("vec%0d_ins_ready", i), 32'(bus.ins_ready), 32'(tbl[i].erdy));
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_outs", i), 32'(bus.outs), 32'(tbl[i].eouts));
      end
    end

    // Streaming: one token per cycle, in order, no gaps.
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, W'(k), 1'b1);
      step();
      chk("stream_outs_valid", 32'(bus.outs_valid), 32'd1);
      chk("stream_outs", 32'(bus.outs), 32'(k));
      chk("stream_ins_ready", 32'(bus.ins_ready), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("stream_drain", 32'(bus.outs_valid), 32'd0);

    // Reset mid-stream with three tokens held.
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0); step();
    drive(1'b1, 8'hA3, 1'b0); step();
    chk("mid_pre_outs", 32'(bus.outs), 32'hA1);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async_outs_valid", 32'(bus.outs_valid), 32'd0);
    chk("mid_async_ins_ready", 32'(bus.ins_ready), 32'd0);
    step();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", 32'(bus.outs_valid), 32'd0);
      chk("mid_ready", 32'(bus.ins_ready), 32'd1);
    end
    drive(1'b1, 8'hB7, 1'b1);
    step();
    chk("mid_new_valid", 32'(bus.outs_valid), 32'd1);
    chk("mid_new_outs", 32'(bus.outs), 32'hB7);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("mid_new_drain", 32'(bus.outs_valid), 32'd0);

    // Random backpressure against a queue scoreboard.
    rdy_m   = 1'b1;
    stall_m = 1'b0;
    held_m  = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(1)), W'($urandom_range(255)), 1'($urandom_range(1)));
      push_m  = bus.ins_valid && rdy_m;
      pop_m   = (q.size() > 0) && bus.outs_ready;
      stall_m = (q.size() > 0) && !bus.outs_ready;
      held_m  = (q.size() > 0) ? q[0] : 8'h00;
      if (pop_m) begin
        void'(q.pop_front());
      end
      if (push_m) begin
        q.push_back(bus.ins);
      end
      rdy_m = (q.size() < N);
      step();
      chk("rnd_outs_valid", 32'(bus.outs_valid), 32'(q.size() > 0));
      chk("rnd_ins_ready", 32'(bus.ins_ready), 32'(rdy_m));
      if (q.size() > 0) begin
        chk("rnd_outs", 32'(bus.outs), 32'(q[0]));
      end
      if (stall_m) begin
        chk("rnd_stable", 32'(bus.outs), 32'(held_m));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
